// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types and widths.
// Default widths plus the controller state encoding.
package dmem_arbiter_pkg;

    localparam int MEM_SPACE = 8;
    localparam int DSIZE     = 16;

    typedef enum logic [1:0] {
        DMARB_IDLE   = 2'd0,
        DMARB_ACCESS = 2'd1,
        DMARB_RESP   = 2'd2
    } dmarb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus bundle.
// Two requester ports plus the single-port memory side.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = MEM_SPACE,
    parameter int DW = DSIZE
) ();

    logic          p0_valid;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ready;
    logic          p0_rvalid;

    logic          p1_valid;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ready;
    logic          p1_rvalid;

    logic [DW-1:0] p_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ready, p0_rvalid,
        output p1_ready, p1_rvalid,
        output p_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ready, p0_rvalid,
        input  p1_ready, p1_rvalid,
        input  p_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic.
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    // one-hot grant, suppressed entirely when not enabled
    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            !enable:               gnt = 2'b00;
            enable && (&req):      gnt = last ? 2'b01 : 2'b10;
            enable && !(&req):     gnt = req;
            default:               gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin access controller for the single-port data memory.
// Serialises two requesters; one access every two cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = MEM_SPACE,
    parameter int DW = DSIZE
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    dmarb_state_e  state_q;
    dmarb_state_e  state_d;
    logic          last_q;
    logic          own_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;

    logic [1:0]    gnt;
    logic          arb_en;
    logic          hs;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // grants only outside ACCESS and never while reset is held
    assign arb_en = rst && (state_q != DMARB_ACCESS);

    rr_arb2 u_arb (
        .req    ({bus.p1_valid, bus.p0_valid}),
        .last   (last_q),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign hs      = |gnt;
    assign w_sel   = gnt[1];
    assign w_we    = w_sel ? bus.p1_we    : bus.p0_we;
    assign w_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
    assign w_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;

    assign bus.p0_ready  = gnt[0];
    assign bus.p1_ready  = gnt[1];
    assign bus.p0_rvalid = (state_q == DMARB_RESP) && !own_q;
    assign bus.p1_rvalid = (state_q == DMARB_RESP) && own_q;
    assign bus.p_rdata   = bus.mem_rdata;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;

    // next-state: RESP may chain straight into another ACCESS
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DMARB_IDLE:   if (hs) state_d = DMARB_ACCESS;
            DMARB_ACCESS: state_d = DMARB_RESP;
            DMARB_RESP:   state_d = hs ? DMARB_ACCESS : DMARB_IDLE;
            default:      state_d = DMARB_IDLE;
        endcase
    end

    // state register; port 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMARB_IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                last_q <= w_sel;
                own_q  <= w_sel;
            end
        end
    end

    // memory-side capture; write strobe lives only in ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            if (hs) begin
                addr_q  <= w_addr;
                wdata_q <= w_wdata;
            end
            if (state_q == DMARB_ACCESS) we_q <= 1'b0;
            else if (hs)                 we_q <= w_we;
        end
    end

endmodule
